// File: rtl/cpu_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boot_ctrl_pkg
// Description : Shared types and constants for the CPU boot/run controller.
//               Holds the host command opcodes, controller states, stop
//               causes, the ECALL encoding and the CPU reset pulse length.
// Revision    : 1.0 - initial release
// ============================================================================
package boot_ctrl_pkg;

  // Host command opcodes
  typedef enum logic [1:0] {
    OP_WR_IMEM = 2'b00,
    OP_WR_DMEM = 2'b01,
    OP_RUN     = 2'b10,
    OP_HALT    = 2'b11
  } cmd_op_e;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CPU_RST = 2'b01,
    ST_RUN     = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  // Reason the last run stopped
  typedef enum logic [1:0] {
    STOP_NONE   = 2'b00,
    STOP_BUDGET = 2'b01,
    STOP_HALT   = 2'b10,
    STOP_ECALL  = 2'b11
  } stop_cause_e;

  localparam logic [31:0] ECALL_INSTR    = 32'h0000_0073;
  localparam int unsigned CPU_RST_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/cpu_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_ctrl_if
// Description : Host command channel (valid/ready) of the boot controller.
//               master = host side, slave = controller side.
//   cmd_valid  host command valid
//   cmd_ready  controller can accept a command
//   cmd_op     WR_IMEM / WR_DMEM / RUN / HALT
//   cmd_addr   byte address for writes
//   cmd_data   write data, or cycle budget for RUN
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_boot_ctrl_if;
  import boot_ctrl_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  cmd_op_e     cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready
  );

endinterface
`default_nettype wire

// File: rtl/cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_boot_ctrl
// Description : Host-side boot and run controller for the single-cycle CPU.
//               Loads instruction/data memory from host commands, resets the
//               CPU, runs it for a bounded number of cycles and freezes it on
//               budget expiry, host HALT or ECALL.
//   clk, rst           clock, synchronous active-high reset
//   cmd                host command channel (slave modport)
//   imem_*_o           instruction memory write port (word index)
//   dmem_host_sel_o    1 = host owns data memory, 0 = CPU owns it
//   dmem_*_o           host data memory write port (byte address)
//   cpu_rst_n_o        active-low CPU reset
//   cpu_en_o           CPU state-update enable
//   pc_i, instr_i      CPU program counter and current instruction
//   done_o             one-cycle pulse when a run stops
//   stop_cause_o       reason of the last stop
//   cycles_run_o       enabled CPU cycles in the current/last run
//   err_o              one-cycle pulse on a rejected command
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  cpu_boot_ctrl_if.slave                     cmd,
  output logic                               imem_we_o,
  output logic [$clog2(IMEM_DEPTH)-1:0]      imem_waddr_o,
  output logic [31:0]                        imem_wdata_o,
  output logic                               dmem_host_sel_o,
  output logic                               dmem_we_o,
  output logic [31:0]                        dmem_waddr_o,
  output logic [31:0]                        dmem_wdata_o,
  output logic                               cpu_rst_n_o,
  output logic                               cpu_en_o,
  input  wire logic [31:0]                   pc_i,
  input  wire logic [31:0]                   instr_i,
  output logic                               done_o,
  output stop_cause_e                        stop_cause_o,
  output logic [31:0]                        cycles_run_o,
  output logic                               err_o
);

  localparam int          IMEM_AW    = $clog2(IMEM_DEPTH);
  localparam int          RC_W       = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;
  localparam logic [29:0] IMEM_WORDS = 30'(IMEM_DEPTH);
  localparam logic [29:0] DMEM_WORDS = 30'(DMEM_DEPTH);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(CPU_RST_CYCLES - 1);

  state_e              state_q, state_d;
  logic [31:0]         budget_q, budget_d;
  logic [31:0]         cycles_q, cycles_d;
  stop_cause_e         cause_q, cause_d;
  logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]  imem_waddr_q, imem_waddr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                dmem_we_q, dmem_we_d;
  logic [31:0]         dmem_waddr_q, dmem_waddr_d;
  logic [31:0]         dmem_wdata_q, dmem_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic accept;
  logic aligned;
  logic imem_ok;
  logic dmem_ok;
  logic is_ecall;
  logic halt_acc;
  logic budget_hit;

  // The controller never looks at the PC; it is only observed by the host.
  logic unused_pc;
  assign unused_pc = ^pc_i;

  assign cmd.cmd_ready = (state_q != ST_CPU_RST);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign aligned       = (cmd.cmd_addr[1:0] == 2'b00);
  assign imem_ok       = aligned && (cmd.cmd_addr[31:2] < IMEM_WORDS);
  assign dmem_ok       = aligned && (cmd.cmd_addr[31:2] < DMEM_WORDS);
  assign is_ecall      = (instr_i == ECALL_INSTR);
  assign halt_acc      = accept && (cmd.cmd_op == OP_HALT);
  // 33-bit compare so the budget test cannot wrap around.
  assign budget_hit    = (({1'b0, cycles_q} + 33'd1) == {1'b0, budget_q});

  always_comb begin
    state_d      = state_q;
    budget_d     = budget_q;
    cycles_d     = cycles_q;
    cause_d      = cause_q;
    rst_cnt_d    = rst_cnt_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_we_d    = 1'b0;
    dmem_waddr_d = dmem_waddr_q;
    dmem_wdata_d = dmem_wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_WR_IMEM: begin
              if (imem_ok) begin
                imem_we_d    = 1'b1;
                imem_waddr_d = cmd.cmd_addr[IMEM_AW+1:2];
                imem_wdata_d = cmd.cmd_data;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_WR_DMEM: begin
              if (dmem_ok) begin
                dmem_we_d    = 1'b1;
                dmem_waddr_d = cmd.cmd_addr;
                dmem_wdata_d = cmd.cmd_data;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_RUN: begin
              if (cmd.cmd_data == 32'd0) begin
                err_d = 1'b1;
              end else begin
                budget_d  = cmd.cmd_data;
                cycles_d  = 32'd0;
                cause_d   = STOP_NONE;
                rst_cnt_d = '0;
                state_d   = ST_CPU_RST;
              end
            end
            default: ; // HALT outside a run is harmless
          endcase
        end
      end

      ST_CPU_RST: begin
        if (rst_cnt_q == RC_LAST) begin
          rst_cnt_d = '0;
          state_d   = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // The current cycle always executes and is counted, even if it stops.
        cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
        if (accept && (cmd.cmd_op != OP_HALT)) begin
          err_d = 1'b1;
        end
        if (is_ecall || halt_acc || budget_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (is_ecall)      cause_d = STOP_ECALL;
          else if (halt_acc) cause_d = STOP_HALT;
          else               cause_d = STOP_BUDGET;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      budget_q     <= 32'd0;
      cycles_q     <= 32'd0;
      cause_q      <= STOP_NONE;
      rst_cnt_q    <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= 32'd0;
      dmem_we_q    <= 1'b0;
      dmem_waddr_q <= 32'd0;
      dmem_wdata_q <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      budget_q     <= budget_d;
      cycles_q     <= cycles_d;
      cause_q      <= cause_d;
      rst_cnt_q    <= rst_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      dmem_waddr_q <= dmem_waddr_d;
      dmem_wdata_q <= dmem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // CPU stays out of reset in DONE so its state can be inspected.
  assign cpu_rst_n_o     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign cpu_en_o        = (state_q == ST_RUN);
  assign dmem_host_sel_o = (state_q != ST_RUN);

  assign imem_we_o    = imem_we_q;
  assign imem_waddr_o = imem_waddr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_waddr_o = dmem_waddr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign done_o       = done_q;
  assign stop_cause_o = cause_q;
  assign cycles_run_o = cycles_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_boot_ctrl
// Description : Directed self-checking bench for cpu_boot_ctrl with a tiny
//               CPU stand-in (PC advances when enabled, halts on ECALL) fed
//               from an instruction memory written through the DUT port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_ctrl;
  import boot_ctrl_pkg::*;

  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        dmem_host_sel;
  logic        dmem_we;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        done;
  stop_cause_e stop_cause;
  logic [31:0] cycles_run;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem_m [IMEM_DEPTH];

  cpu_boot_ctrl_if bus ();

  cpu_boot_ctrl #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (bus.slave),
    .imem_we_o       (imem_we),
    .imem_waddr_o    (imem_waddr),
    .imem_wdata_o    (imem_wdata),
    .dmem_host_sel_o (dmem_host_sel),
    .dmem_we_o       (dmem_we),
    .dmem_waddr_o    (dmem_waddr),
    .dmem_wdata_o    (dmem_wdata),
    .cpu_rst_n_o     (cpu_rst_n),
    .cpu_en_o        (cpu_en),
    .pc_i            (pc),
    .instr_i         (instr),
    .done_o          (done),
    .stop_cause_o    (stop_cause),
    .cycles_run_o    (cycles_run),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU stand-in: NOP everywhere by default, ECALL holds the PC.
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem_m[i] = 32'h0000_0013;
  end
  always @(posedge clk) begin
    if (imem_we) imem_m[imem_waddr] <= imem_wdata;
  end
  assign instr = imem_m[pc[9:2]];
  always @(posedge clk) begin
    if (!cpu_rst_n)                           pc <= 32'd0;
    else if (cpu_en && instr != ECALL_INSTR)  pc <= pc + 32'd4;
  end

  task automatic send(input cmd_op_e op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Counts reset and enabled cycles from the cycle after a RUN accept until done.
  task automatic run_measure(output int rstc, output int enc, output bit seen);
    rstc = 0; enc = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (!cpu_rst_n) rstc++;
      if (cpu_en) enc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HALT;
    bus.cmd_addr  = 32'd0;
    bus.cmd_data  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready); end
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst_n got %b exp 0", cpu_rst_n); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b exp 0", cpu_en); end
    checks++; if (dmem_host_sel !== 1'b1) begin errors++; $display("FAIL reset_host_sel got %b exp 1", dmem_host_sel); end
    checks++; if (cycles_run !== 32'd0) begin errors++; $display("FAIL reset_cycles got %0d exp 0", cycles_run); end
    checks++; if ({done, err, imem_we, dmem_we} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {done, err, imem_we, dmem_we}); end
    checks++; if (stop_cause !== STOP_NONE) begin errors++; $display("FAIL reset_cause got %0d exp 0", stop_cause); end
    checks++; if ({imem_waddr, dmem_waddr, imem_wdata, dmem_wdata} !== '0) begin errors++; $display("FAIL reset_addr_data got nonzero exp 0"); end
    rst = 1'b0;
  endtask

  task automatic test_writes;
    send(OP_WR_IMEM, 32'h8, 32'h0031_00B3);
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL wr_imem_we got %b exp 1", imem_we); end
    checks++; if (imem_waddr !== 8'd2) begin errors++; $display("FAIL wr_imem_waddr got %0d exp 2", imem_waddr); end
    checks++; if (imem_wdata !== 32'h0031_00B3) begin errors++; $display("FAIL wr_imem_wdata got %h exp 003100b3", imem_wdata); end
    @(negedge clk);
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL wr_imem_one_cycle got %b exp 0", imem_we); end
    send(OP_WR_IMEM, 32'h6, 32'h1234_5678);
    checks++; if ({err, imem_we} !== 2'b10) begin errors++; $display("FAIL wr_misaligned err/we got %b exp 10", {err, imem_we}); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b exp 0", err); end
    send(OP_WR_IMEM, 32'(IMEM_DEPTH * 4), 32'h1);
    checks++; if ({err, imem_we} !== 2'b10) begin errors++; $display("FAIL wr_out_of_range err/we got %b exp 10", {err, imem_we}); end
    send(OP_WR_IMEM, 32'(IMEM_DEPTH * 4 - 4), 32'h0000_0013);
    checks++; if ({err, imem_we, imem_waddr} !== {2'b01, 8'd255}) begin errors++; $display("FAIL wr_last_word got %b/%0d exp 01/255", {err, imem_we}, imem_waddr); end
    // Back-to-back data memory writes
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WR_DMEM; bus.cmd_addr = 32'h10; bus.cmd_data = 32'hAAAA_0001;
    @(negedge clk);
    checks++; if ({dmem_we, dmem_waddr, dmem_wdata} !== {1'b1, 32'h10, 32'hAAAA_0001}) begin errors++; $display("FAIL wr_dmem_1 got %b %h %h exp 1 10 aaaa0001", dmem_we, dmem_waddr, dmem_wdata); end
    bus.cmd_addr = 32'h14; bus.cmd_data = 32'hAAAA_0002;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if ({dmem_we, dmem_waddr, dmem_wdata} !== {1'b1, 32'h14, 32'hAAAA_0002}) begin errors++; $display("FAIL wr_dmem_2 got %b %h %h exp 1 14 aaaa0002", dmem_we, dmem_waddr, dmem_wdata); end
    @(negedge clk);
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL wr_dmem_end got %b exp 0", dmem_we); end
  endtask

  task automatic test_run_zero;
    send(OP_RUN, 32'h0, 32'd0);
    checks++; if ({err, bus.cmd_ready, cpu_rst_n} !== 3'b110) begin errors++; $display("FAIL run_zero err/ready/rst_n got %b exp 110", {err, bus.cmd_ready, cpu_rst_n}); end
    @(negedge clk);
    checks++; if ({bus.cmd_ready, cpu_en, cpu_rst_n} !== 3'b100) begin errors++; $display("FAIL run_zero_idle got %b exp 100", {bus.cmd_ready, cpu_en, cpu_rst_n}); end
  endtask

  task automatic test_run_budget;
    int rstc, enc; bit seen;
    send(OP_RUN, 32'h0, 32'd20);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL cpu_rst_ready got %b exp 0", bus.cmd_ready); end
    run_measure(rstc, enc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL budget_timeout got no done exp done"); end
    checks++; if (rstc !== 2) begin errors++; $display("FAIL budget_rst_cycles got %0d exp 2", rstc); end
    checks++; if (enc !== 20) begin errors++; $display("FAIL budget_en_cycles got %0d exp 20", enc); end
    checks++; if (stop_cause !== STOP_BUDGET) begin errors++; $display("FAIL budget_cause got %0d exp 1", stop_cause); end
    checks++; if (cycles_run !== 32'd20) begin errors++; $display("FAIL budget_cycles_run got %0d exp 20", cycles_run); end
    checks++; if ({cpu_rst_n, cpu_en, dmem_host_sel} !== 3'b101) begin errors++; $display("FAIL budget_done_ctrl got %b exp 101", {cpu_rst_n, cpu_en, dmem_host_sel}); end
    checks++; if (pc !== 32'd80) begin errors++; $display("FAIL budget_pc got %h exp 50", pc); end
    @(negedge clk);
    checks++; if ({done, cpu_en, cpu_rst_n} !== 3'b001) begin errors++; $display("FAIL done_one_cycle got %b exp 001", {done, cpu_en, cpu_rst_n}); end
  endtask

  task automatic test_ecall;
    int rstc, enc; bit seen;
    send(OP_WR_IMEM, 32'h14, ECALL_INSTR);
    send(OP_RUN, 32'h0, 32'd100);
    run_measure(rstc, enc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ecall_timeout got no done exp done"); end
    checks++; if (enc !== 6 || cycles_run !== 32'd6) begin errors++; $display("FAIL ecall_cycles got %0d/%0d exp 6/6", enc, cycles_run); end
    checks++; if (stop_cause !== STOP_ECALL) begin errors++; $display("FAIL ecall_cause got %0d exp 3", stop_cause); end
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL ecall_pc got %h exp 14", pc); end
    send(OP_WR_IMEM, 32'h14, 32'h0000_0013);
  endtask

  task automatic test_halt;
    int enc; bit seen; bit prev_en;
    enc = 0; seen = 1'b0; prev_en = 1'b0;
    send(OP_RUN, 32'h0, 32'd100);
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (cpu_en) enc++;
      prev_en = cpu_en;
      if (cpu_en && enc == 4) begin
        bus.cmd_valid = 1'b0;
        checks++; if ({err, dmem_we, dmem_host_sel} !== 3'b100) begin errors++; $display("FAIL run_wr_dmem err/we/sel got %b exp 100", {err, dmem_we, dmem_host_sel}); end
      end
      if (cpu_en && enc == 3) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_WR_DMEM; bus.cmd_addr = 32'h20; bus.cmd_data = 32'hDEAD_BEEF;
      end
      if (cpu_en && enc == 10) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_HALT;
      end else if (enc > 10 || (cpu_en && enc == 4)) begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (enc == 10) bus.cmd_valid = 1'b0;
    end
    checks++; if (!seen) begin errors++; $display("FAIL halt_timeout got no done exp done"); end
    checks++; if (enc !== 10 || !prev_en) begin errors++; $display("FAIL halt_en_cycles got %0d/%b exp 10/1", enc, prev_en); end
    checks++; if (stop_cause !== STOP_HALT || cycles_run !== 32'd10) begin errors++; $display("FAIL halt_cause got %0d/%0d exp 2/10", stop_cause, cycles_run); end
  endtask

  task automatic test_ecall_and_halt;
    int enc; bit seen;
    enc = 0; seen = 1'b0;
    send(OP_WR_IMEM, 32'h8, ECALL_INSTR);
    send(OP_RUN, 32'h0, 32'd100);
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (cpu_en) enc++;
      if (cpu_en && enc == 3) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_HALT;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    checks++; if (!seen || stop_cause !== STOP_ECALL || cycles_run !== 32'd3) begin errors++; $display("FAIL ecall_halt got %b/%0d/%0d exp 1/3/3", seen, stop_cause, cycles_run); end
    send(OP_WR_IMEM, 32'h8, 32'h0000_0013);
  endtask

  task automatic test_rst_mid_run;
    int enc;
    enc = 0;
    send(OP_RUN, 32'h0, 32'd100);
    for (int i = 0; i < 50; i++) begin
      if (cpu_en) enc++;
      if (enc == 5) break;
      @(negedge clk);
    end
    checks++; if (enc !== 5) begin errors++; $display("FAIL rst_run_reach got %0d exp 5", enc); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({cpu_rst_n, cpu_en, dmem_host_sel, bus.cmd_ready} !== 4'b0011) begin errors++; $display("FAIL rst_run_ctrl got %b exp 0011", {cpu_rst_n, cpu_en, dmem_host_sel, bus.cmd_ready}); end
    checks++; if (cycles_run !== 32'd0 || stop_cause !== STOP_NONE || done !== 1'b0) begin errors++; $display("FAIL rst_run_status got %0d/%0d/%b exp 0/0/0", cycles_run, stop_cause, done); end
    @(negedge clk);
    checks++; if ({cpu_rst_n, cpu_en} !== 2'b00) begin errors++; $display("FAIL rst_run_stays_idle got %b exp 00", {cpu_rst_n, cpu_en}); end
  endtask

  initial begin
    test_reset;
    test_writes;
    test_run_zero;
    test_run_budget;
    test_ecall;
    test_halt;
    test_ecall_and_halt;
    test_rst_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
